// File: rtl/y86_hazard_scoreboard.sv
// Execute-stage forwarding scoreboard: tracks EX/MEM/WB destinations, drives
// per-operand forward selects, detects load-use hazards and counts stall cycles.

module y86_fwd_sel #(
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic            dec_valid_i,
  input  logic [3:0]      src_i,
  input  logic [2:0]      vld_i,   // [0]=EX [1]=MEM [2]=WB
  input  logic [2:0][3:0] dste_i,
  input  logic [2:0][3:0] dstm_i,
  output logic [2:0]      sel_o
);
  // EX.dstM is deliberately absent: a load in EX cannot be forwarded yet.
  always_comb begin
    sel_o = 3'd0;
    if (dec_valid_i && src_i != RNONE) begin
      if      (vld_i[0] && src_i == dste_i[0]) sel_o = 3'd1;
      else if (vld_i[1] && src_i == dstm_i[1]) sel_o = 3'd2;
      else if (vld_i[1] && src_i == dste_i[1]) sel_o = 3'd3;
      else if (vld_i[2] && src_i == dstm_i[2]) sel_o = 3'd4;
      else if (vld_i[2] && src_i == dste_i[2]) sel_o = 3'd5;
    end
  end
endmodule

module y86_hazard_scoreboard #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [3:0]       dec_srcA,
  input  logic [3:0]       dec_srcB,
  input  logic [3:0]       dec_dstE,
  input  logic [3:0]       dec_dstM,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall_fd,
  output logic             bubble_e,
  output logic [2:0]       fwdA_sel,
  output logic [2:0]       fwdB_sel,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_OPS = 2;

  logic [2:0]             vld_q;
  logic [2:0][3:0]        dste_q, dstm_q;
  logic                   ex_vld_d;
  logic [3:0]             ex_dste_d, ex_dstm_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_OPS-1:0][3:0] src;
  logic [NUM_OPS-1:0][2:0] sel;
  logic                   hazard;

  assign src = {dec_srcB, dec_srcA};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    y86_fwd_sel #(.RNONE(RNONE)) u_fwd (
      .dec_valid_i(dec_valid),
      .src_i      (src[g]),
      .vld_i      (vld_q),
      .dste_i     (dste_q),
      .dstm_i     (dstm_q),
      .sel_o      (sel[g])
    );
  end

  assign hazard = dec_valid && vld_q[0] && dstm_q[0] != RNONE &&
                  (dec_srcA == dstm_q[0] || dec_srcB == dstm_q[0]);

  // Outputs are forced low while reset is asserted, even if flush is high.
  assign stall_fd  = rst_n && hazard && !flush;
  assign bubble_e  = rst_n && (hazard || flush);
  assign fwdA_sel  = rst_n ? sel[0] : 3'd0;
  assign fwdB_sel  = rst_n ? sel[1] : 3'd0;
  assign stall_cnt = cnt_q;

  assign ex_vld_d  = dec_valid && !bubble_e;
  assign ex_dste_d = ex_vld_d ? dec_dstE : RNONE;
  assign ex_dstm_d = ex_vld_d ? dec_dstM : RNONE;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                       cnt_d = '0;
    else if (stall_fd && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      dste_q <= {3{RNONE}};
      dstm_q <= {3{RNONE}};
      cnt_q  <= '0;
    end else begin
      vld_q  <= {vld_q[1:0], ex_vld_d};
      dste_q <= {dste_q[1:0], ex_dste_d};
      dstm_q <= {dstm_q[1:0], ex_dstm_d};
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_y86_hazard_scoreboard.sv
// Bench for y86_hazard_scoreboard: directed table, corner sequences and
// random traffic checked against a queue-based pipeline model.

module tb_y86_hazard_scoreboard;
  localparam logic [3:0] F = 4'hF;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dec_valid = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [3:0] dec_srcA = F, dec_srcB = F, dec_dstE = F, dec_dstM = F;
  logic stall_fd, bubble_e;
  logic [2:0] fwdA_sel, fwdB_sel;
  logic [CNT_W-1:0] stall_cnt;

  y86_hazard_scoreboard #(.RNONE(F), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_srcA(dec_srcA), .dec_srcB(dec_srcB), .dec_dstE(dec_dstE), .dec_dstM(dec_dstM),
    .flush(flush), .cnt_clr(cnt_clr), .stall_fd(stall_fd), .bubble_e(bubble_e),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of instructions in flight, front = youngest (EX).
  typedef struct { bit v; logic [3:0] e; logic [3:0] m; } ins_t;
  ins_t pq[$];
  int   m_cnt;
  int   e_st, e_bu, e_sa, e_sb;

  function automatic void model_reset();
    ins_t b = '{0, F, F};
    pq = {b, b, b};
    m_cnt = 0;
  endfunction

  function automatic int ref_sel(input logic dv, input logic [3:0] s);
    if (!dv || s == F) return 0;
    if (pq[0].v && pq[0].e == s) return 1;
    if (pq[1].v && pq[1].m == s) return 2;
    if (pq[1].v && pq[1].e == s) return 3;
    if (pq[2].v && pq[2].m == s) return 4;
    if (pq[2].v && pq[2].e == s) return 5;
    return 0;
  endfunction

  // Drive inputs just after negedge, check against model before the edge.
  task automatic apply(input logic dv, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] e, input logic [3:0] m,
                       input logic fl, input logic clr);
    bit hz;
    dec_valid = dv; dec_srcA = a; dec_srcB = b; dec_dstE = e; dec_dstM = m;
    flush = fl; cnt_clr = clr;
    #1;
    hz = dv && pq[0].v && pq[0].m != F && (a == pq[0].m || b == pq[0].m);
    e_st = (hz && !fl) ? 1 : 0;
    e_bu = (hz || fl) ? 1 : 0;
    e_sa = ref_sel(dv, a);
    e_sb = ref_sel(dv, b);
    chk("stall_fd", int'(stall_fd), e_st);
    chk("bubble_e", int'(bubble_e), e_bu);
    chk("fwdA_sel", int'(fwdA_sel), e_sa);
    chk("fwdB_sel", int'(fwdB_sel), e_sb);
    chk("stall_cnt", int'(stall_cnt), m_cnt);
  endtask

  task automatic tick();
    ins_t n;
    @(posedge clk);
    if (e_bu == 1 || !dec_valid) n = '{0, F, F};
    else n = '{1, dec_dstE, dec_dstM};
    pq.push_front(n);
    void'(pq.pop_back());
    if (cnt_clr) m_cnt = 0;
    else if (e_st == 1 && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
  endtask

  task automatic step(input logic dv, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] e, input logic [3:0] m,
                      input logic fl, input logic clr);
    apply(dv, a, b, e, m, fl, clr);
    tick();
  endtask

  typedef struct {
    logic dv; logic [3:0] a, b, e, m; logic fl, clr;
    int st, bu, sa, sb, cnt;
  } vec_t;

  function automatic vec_t v(input logic dv, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] e, input logic [3:0] m, input logic fl,
                             input logic clr, input int st, input int bu,
                             input int sa, input int sb, input int cnt);
    vec_t r;
    r.dv = dv; r.a = a; r.b = b; r.e = e; r.m = m; r.fl = fl; r.clr = clr;
    r.st = st; r.bu = bu; r.sa = sa; r.sb = sb; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 3) == 0) return F;
    return 4'($urandom_range(0, 7));
  endfunction

  vec_t tbl[24];

  initial begin
    tbl[0]  = v(1, 3, F, F, F, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, F, F, 2, F, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 2, 2, F, F, 0, 0, 0, 0, 1, 1, 0);
    tbl[3]  = v(1, 2, 2, F, F, 0, 0, 0, 0, 3, 3, 0);
    tbl[4]  = v(1, 2, 2, F, F, 0, 0, 0, 0, 5, 5, 0);
    tbl[5]  = v(1, 2, 2, F, F, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = v(1, F, F, F, 5, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(1, F, 5, F, F, 0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = v(1, F, 5, F, F, 0, 0, 0, 0, 0, 2, 1);
    tbl[9]  = v(1, F, F, F, 6, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = v(1, 6, F, 7, F, 1, 0, 0, 1, 0, 0, 1);
    tbl[11] = v(1, 7, 6, F, F, 0, 0, 0, 0, 0, 2, 1);
    tbl[12] = v(1, F, F, F, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = v(1, F, F, 1, F, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = v(1, 1, F, F, F, 0, 0, 0, 0, 1, 0, 1);
    tbl[15] = v(1, F, F, F, F, 0, 0, 0, 0, 0, 0, 1);
    tbl[16] = v(1, F, F, 4, 4, 0, 0, 0, 0, 0, 0, 1);
    tbl[17] = v(1, F, F, F, F, 0, 0, 0, 0, 0, 0, 1);
    tbl[18] = v(1, 4, 4, F, F, 0, 0, 0, 0, 2, 2, 1);
    tbl[19] = v(1, 4, 4, F, F, 0, 0, 0, 0, 4, 4, 1);
    tbl[20] = v(0, 4, F, F, F, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = v(1, 4, F, F, F, 0, 0, 0, 0, 0, 0, 1);
    tbl[22] = v(1, F, F, F, F, 0, 1, 0, 0, 0, 0, 1);
    tbl[23] = v(1, F, F, F, F, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, with flush high to show outputs are held low.
    model_reset();
    flush = 1'b1; dec_valid = 1'b1; dec_srcA = 4'd3;
    #3;
    chk("rst_stall", int'(stall_fd), 0);
    chk("rst_bubble", int'(bubble_e), 0);
    chk("rst_selA", int'(fwdA_sel), 0);
    chk("rst_selB", int'(fwdB_sel), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].dv, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].m, tbl[i].fl, tbl[i].clr);
      chk($sformatf("tbl%0d_stall", i), int'(stall_fd), tbl[i].st);
      chk($sformatf("tbl%0d_bubble", i), int'(bubble_e), tbl[i].bu);
      chk($sformatf("tbl%0d_selA", i), int'(fwdA_sel), tbl[i].sa);
      chk($sformatf("tbl%0d_selB", i), int'(fwdB_sel), tbl[i].sb);
      chk($sformatf("tbl%0d_cnt", i), int'(stall_cnt), tbl[i].cnt);
      tick();
    end

    // Saturation: five load-use stalls on a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      step(1, F, F, F, 5, 0, 0);
      step(1, F, 5, F, F, 0, 0);
    end
    chk("sat_cnt", int'(stall_cnt), CMAX);
    // Clear wins over a coincident stall.
    step(1, F, F, F, 5, 0, 0);
    apply(1, 5, F, F, F, 0, 1);
    chk("clr_stall_seen", int'(stall_fd), 1);
    tick();
    chk("clr_cnt", int'(stall_cnt), 0);

    // Async reset mid-stream with a load sitting in EX.
    step(1, F, F, F, 5, 0, 0);
    step(1, F, F, F, 3, 0, 0);
    apply(1, F, 3, F, F, 0, 0);
    chk("pre_rst_stall", int'(stall_fd), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", int'(stall_fd), 0);
    chk("mid_rst_bubble", int'(bubble_e), 0);
    chk("mid_rst_cnt", int'(stall_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 5, 3, F, F, 0, 0);
    chk("post_rst_stall", int'(stall_fd), 0);
    chk("post_rst_selA", int'(fwdA_sel), 0);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) != 0), rreg(), rreg(), rreg(), rreg(),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
